led_seq: RTL and testbench
==========================

# led_seq

Parametrised LED sequencer that drives `NUM_LED` board LEDs with a selectable chase pattern at a programmable step rate.
- It is the general-purpose status/heartbeat indicator: the top level ties it to the 50 MHz board clock and the reset key, and drives the LED pins directly.
- Pattern mode, pause and step period are run-time or elaboration-time controls.
- LED polarity is a parameter, so the block fits boards with either LED wiring.

## Interface
- `NUM_LED`, 4: number of LEDs; ≥1.
- `STEP_CYCLES`, 10_000_000: clock cycles per pattern step (0.2 s at 50 MHz); ≥2.
- `ACTIVE_LOW`, 1: 1 means an output of 0 lights the LED.
- `PWM_BITS`, 4: PWM resolution; used only with `LED_SEQ_PWM_EN`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `en` in 1: 1 = run, 0 = pause (prescaler frozen).
- `mode` in 2: 00 shift-up, 01 shift-down, 10 bounce, 11 blink-all.
- `led` out `NUM_LED`: LED drive, registered, polarity per `ACTIVE_LOW`.
- `step_tick` out 1: one-cycle pulse on each pattern step.
- `pos` out max(1,clog2(`NUM_LED`)): current lit index.
- `duty` in `PWM_BITS`: brightness; port exists only with `LED_SEQ_PWM_EN`.

## Operation
- **Prescaler** `cnt`, width clog2(`STEP_CYCLES`):
  - Increments while `en`=1; holds while `en`=0.
  - At `STEP_CYCLES`-1 it wraps to 0 and asserts `step_tick` for that cycle.
- **State:** `pos`, `dir` (up/down), `phase` (blink), `mode_q` (active mode). All update only on a `step_tick` cycle.
- **Mode sampling:** `mode` is sampled only on `step_tick`. If `mode` ≠ `mode_q`:
  - `mode_q`←`mode`.
  - `pos`←0 (modes 00/10) or `NUM_LED`-1 (mode 01).
  - `dir`←up, `phase`←1.
  - No other advance occurs that step.
- **Advance**, per `mode_q`, when `mode` = `mode_q`:
  - 00: `pos`←`pos`+1, wrapping from `NUM_LED`-1 to 0.
  - 01: `pos`←`pos`-1, wrapping from 0 to `NUM_LED`-1.
  - 10: moves in `dir`. At `NUM_LED`-1 going up, `dir` flips and `pos`←`NUM_LED`-2. At 0 going down, `dir` flips and `pos`←1. Endpoints are never repeated.
  - 11: `phase` toggles; `pos` holds.
- **Logical pattern:**
  - Modes 00–10: one-hot of `pos`.
  - Mode 11: all ones when `phase`=1, all zeros when `phase`=0.
- **Output:** `led` = registered logical pattern, XOR all-ones if `ACTIVE_LOW`=1.
- **`NUM_LED`=1:** `pos` is constant 0 in all modes. Bounce never flips and stays at index 0.
- **Reset** (asynchronous, any time, including mid-step):
  - `cnt`=0, `pos`=0, `dir`=up, `phase`=0, `mode_q`=00, `step_tick`=0.
  - `led` = one-hot bit 0, polarity applied (1110 for default parameters).
- **After reset release:** the first `step_tick` occurs exactly `STEP_CYCLES` enabled cycles later.

## Timing
- `step_tick` and the new `pos` become visible on the same clock edge.
- `led` reflects the new state one cycle later (1-cycle output latency).
- Step period is exactly `STEP_CYCLES` cycles of `en`=1; paused cycles do not count.
- Deasserting `en` on the terminal-count cycle suppresses that tick. The tick occurs on the first enabled cycle after resume.
- A `mode` change latency is up to `STEP_CYCLES` cycles, with effect at the next tick.
- `mode` needs no synchronisation beyond `clk`; the caller provides a synchronous `mode`.

## Configuration
- **`LED_SEQ_PWM_EN` defined:**
  - Adds the `duty` input and a free-running `PWM_BITS` counter `pc`, reset to 0.
  - A logically lit LED is driven on only while `pc` < `duty`. Gating is applied before polarity inversion.
  - `duty`=0 gives all LEDs off.
  - Maximum brightness is (2^`PWM_BITS`-1)/2^`PWM_BITS`.
- **Undefined:** no `duty` port and no PWM counter; lit LEDs are steady on.

## Test plan
Bench parameters, unless noted: `NUM_LED`=4, `STEP_CYCLES`=4, `ACTIVE_LOW`=1.

1. Assert `rst_n`=0 mid-run, then release with `en`=1, `mode`=00 → `led`=1110 during reset. First `step_tick` 4 cycles after release. `led` sequence 1110,1101,1011,0111,1110.
2. `mode`=01 from reset → at first tick `pos`=3 (mode-change load). Then `pos` 2,1,0,3. `led` after first tick = 0111.
3. `mode`=10 → `pos` 0,1,2,3,2,1,0,1 on successive ticks; no repeated endpoints.
4. `mode`=00; drop `en` for 10 cycles when `cnt`=2 → no `step_tick` and `led` frozen. The next tick arrives 2 enabled cycles after resume.
5. Change `mode` 00→11 mid-step → no change until the next tick. Then `led` 0000, 1111, 0000 on successive ticks.
6. With `LED_SEQ_PWM_EN`, `PWM_BITS`=4, `duty`=8 → the lit LED is low 8 of every 16 cycles. With `duty`=0, `led`=1111 constantly.

Source files
------------

// File: rtl/led_seq.sv
// Chase-pattern LED sequencer: prescaled step tick, shift/bounce/blink patterns, polarity select.
// Optional PWM brightness gating is built in when LED_SEQ_PWM_EN is defined.
module led_seq #(
    parameter int unsigned NUM_LED     = 4,
    parameter int unsigned STEP_CYCLES = 10_000_000,
    parameter int unsigned ACTIVE_LOW  = 1,
    parameter int unsigned PWM_BITS    = 4,
    localparam int unsigned PW         = (NUM_LED > 1) ? $clog2(NUM_LED) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
`ifdef LED_SEQ_PWM_EN
    input  logic [PWM_BITS-1:0] duty,
`endif
    output logic [NUM_LED-1:0]  led,
    output logic                step_tick,
    output logic [PW-1:0]       pos
);

    localparam int unsigned CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(NUM_LED - 1);
    localparam logic [PW-1:0] POS_PEN  = PW'((NUM_LED > 1) ? NUM_LED - 2 : 0);
    localparam logic [NUM_LED-1:0] LED_RST = (ACTIVE_LOW != 0) ? ~NUM_LED'(1) : NUM_LED'(1);

    localparam logic [1:0] MODE_UP  = 2'b00;
    localparam logic [1:0] MODE_DN  = 2'b01;
    localparam logic [1:0] MODE_BNC = 2'b10;
    localparam logic       DIR_UP   = 1'b0;
    localparam logic       DIR_DN   = 1'b1;

    if (NUM_LED < 1 || STEP_CYCLES < 2 || PWM_BITS < 1) begin : g_param_check
        $error("led_seq: illegal parameter value");
    end

    logic [CW-1:0]      cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic               dir_q, dir_d;
    logic               phase_q, phase_d;
    logic [1:0]         mode_q, mode_d;
    logic [NUM_LED-1:0] led_q, led_d;
    logic [NUM_LED-1:0] pat_c;
    logic               lit_c;

`ifdef LED_SEQ_PWM_EN
    logic [PWM_BITS-1:0] pc_q;

    // Free-running brightness counter; lit LEDs are on while pc < duty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_q + PWM_BITS'(1);
        end
    end

    assign lit_c = (pc_q < duty);
`else
    assign lit_c = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
            phase_q <= 1'b0;
            mode_q  <= MODE_UP;
            led_q   <= LED_RST;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
        end
    end

    // Prescaler and pattern state advance; a mode change reloads instead of advancing.
    always_comb begin
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        pos_d   = pos_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        mode_d  = mode_q;

        if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (tick_d) begin
            if (mode != mode_q) begin
                mode_d  = mode;
                pos_d   = (mode == MODE_DN) ? POS_LAST : '0;
                dir_d   = DIR_UP;
                phase_d = 1'b1;
            end else begin
                case (mode_q)
                    MODE_UP: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
                    MODE_DN: pos_d = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
                    MODE_BNC: begin
                        if (NUM_LED > 1) begin
                            if (dir_q == DIR_UP) begin
                                if (pos_q == POS_LAST) begin
                                    dir_d = DIR_DN;
                                    pos_d = POS_PEN;
                                end else begin
                                    pos_d = pos_q + PW'(1);
                                end
                            end else begin
                                if (pos_q == '0) begin
                                    dir_d = DIR_UP;
                                    pos_d = PW'(1);
                                end else begin
                                    pos_d = pos_q - PW'(1);
                                end
                            end
                        end
                    end
                    default: phase_d = ~phase_q;
                endcase
            end
        end
    end

    // Logical pattern from current state, then brightness gate, then polarity.
    always_comb begin
        pat_c = '0;
        for (int i = 0; i < int'(NUM_LED); i++) begin
            pat_c[i] = (pos_q == PW'(i));
        end
        if (mode_q == 2'b11) begin
            pat_c = {NUM_LED{phase_q}};
        end
        if (!lit_c) begin
            pat_c = '0;
        end
        led_d = (ACTIVE_LOW != 0) ? ~pat_c : pat_c;
    end

    assign led       = led_q;
    assign step_tick = tick_q;
    assign pos       = pos_q;

endmodule

// File: tb/tb_led_seq.sv
// Bench for led_seq: directed scenarios plus random en/mode traffic checked against an
// arithmetic model (pattern position derived from mode and number of advances since load).
module tb_led_seq;

    localparam int N  = 4;
    localparam int SC = 4;
    localparam int AL = 1;
    localparam int PB = 4;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [N-1:0] led;
    logic         step_tick;
    logic [1:0]   pos;
`ifdef LED_SEQ_PWM_EN
    logic [PB-1:0] duty;
`endif

    int vectors;
    int miscompares;
    int m_ecnt;
    int m_mode;
    int m_k;
    int m_pc;

    led_seq #(
        .NUM_LED    (N),
        .STEP_CYCLES(SC),
        .ACTIVE_LOW (AL),
        .PWM_BITS   (PB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
`ifdef LED_SEQ_PWM_EN
        .duty     (duty),
`endif
        .led      (led),
        .step_tick(step_tick),
        .pos      (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected index after k advances since the mode was loaded.
    function automatic int exp_pos(input int md, input int k);
        int p;
        case (md)
            0: return k % N;
            1: return N - 1 - (k % N);
            2: begin
                if (N == 1) return 0;
                p = k % (2 * N - 2);
                return (p < N) ? p : (2 * N - 2 - p);
            end
            default: return 0;
        endcase
    endfunction

    function automatic logic [N-1:0] pattern_of(input int md, input int k);
        logic [N-1:0] p;
        if (md == 3) begin
            p = ((k % 2) == 0) ? {N{1'b1}} : {N{1'b0}};
        end else begin
            p = '0;
            p[exp_pos(md, k)] = 1'b1;
        end
        return p;
    endfunction

    function automatic logic [N-1:0] polar(input logic [N-1:0] p);
        return (AL != 0) ? ~p : p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ecnt = 0;
        m_mode = 0;
        m_k    = 0;
        m_pc   = 0;
    endtask

    // One clock with the given inputs; model predicts tick, pos and registered led.
    task automatic cyc(input logic e, input logic [1:0] m);
        logic [N-1:0] pat;
        logic         exp_tick;
        en   = e;
        mode = m;
        @(posedge clk);
        pat = pattern_of(m_mode, m_k);
`ifdef LED_SEQ_PWM_EN
        if (!(m_pc < int'(duty))) pat = '0;
        m_pc = (m_pc + 1) % (1 << PB);
`endif
        exp_tick = 1'b0;
        if (e) begin
            m_ecnt++;
            if (m_ecnt == SC) begin
                m_ecnt   = 0;
                exp_tick = 1'b1;
                if (int'(m) != m_mode) begin
                    m_mode = int'(m);
                    m_k    = 0;
                end else begin
                    m_k++;
                end
            end
        end
        #1;
        check("tick", 32'(step_tick), 32'(exp_tick));
        if (m_mode != 3) check("pos", 32'(pos), 32'(exp_pos(m_mode, m_k)));
        check("led", 32'(led), 32'(polar(pattern_of_gated(pat))));
    endtask

    function automatic logic [N-1:0] pattern_of_gated(input logic [N-1:0] p);
        return p;
    endfunction

    // Asynchronous reset asserted mid-cycle, held across one edge, released on a falling edge.
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_led", 32'(led), 32'(4'b1110));
        check("rst_tick", 32'(step_tick), 32'd0);
        check("rst_pos", 32'(pos), 32'd0);
        @(posedge clk);
        #1;
        check("rst_led_hold", 32'(led), 32'(4'b1110));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [1:0] rmode;
        int         lit;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        en          = 1'b0;
        mode        = 2'b00;
`ifdef LED_SEQ_PWM_EN
        duty        = PB'(15);
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_led", 32'(led), 32'(4'b1110));
        check("init_pos", 32'(pos), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Shift-up, with a reset landing mid-run.
        repeat (3) cyc(1'b1, 2'b00);
        apply_reset();
        repeat (20) cyc(1'b1, 2'b00);

        // Shift-down from reset: first tick loads the top index.
        apply_reset();
        repeat (20) cyc(1'b1, 2'b01);

        // Bounce.
        apply_reset();
        repeat (36) cyc(1'b1, 2'b10);

        // Pause at cnt=2, then resume.
        apply_reset();
        repeat (2) cyc(1'b1, 2'b00);
        repeat (10) cyc(1'b0, 2'b00);
        repeat (12) cyc(1'b1, 2'b00);

        // Pause on the terminal-count cycle suppresses the tick until resume.
        for (int i = 0; i < SC && m_ecnt != SC - 1; i++) cyc(1'b1, 2'b00);
        cyc(1'b0, 2'b00);
        cyc(1'b0, 2'b00);
        cyc(1'b1, 2'b00);

        // Mode change to blink mid-step.
        apply_reset();
        repeat (5) cyc(1'b1, 2'b00);
        repeat (16) cyc(1'b1, 2'b11);

        // Random traffic.
        rmode = 2'b00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) rmode = 2'($urandom_range(0, 3));
`ifdef LED_SEQ_PWM_EN
            if ($urandom_range(0, 31) == 0) duty = PB'($urandom_range(0, 15));
`endif
            if (i == 300) apply_reset();
            cyc($urandom_range(0, 4) != 0, rmode);
        end

`ifdef LED_SEQ_PWM_EN
        // Brightness: with the pattern frozen on index 0, count lit cycles per PWM period.
        apply_reset();
        duty = PB'(8);
        lit  = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 2'b00);
            if (led == 4'b1110) lit++;
        end
        check("pwm_duty8", 32'(lit), 32'd8);
        duty = PB'(0);
        cyc(1'b0, 2'b00);
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 2'b00);
            if (led == 4'b1111) lit++;
        end
        check("pwm_duty0", 32'(lit), 32'd16);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
